// File: rtl/debounced_gate.sv
`default_nettype none
// ============================================================================
// Module   : debounced_gate
// Purpose  : Synchronise and debounce N switches, apply a selectable gate
//            function, and flag/count changes of the gate result.
// Revision : 1.0
// ============================================================================
module debounced_gate #(
    parameter int N    = 2,
    parameter int DEB  = 4,
    parameter int CNTW = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    SW,
    input  logic [1:0]      MODE,
    output logic [N-1:0]    SWD,
    output logic            L,
    output logic            EDGE,
    output logic [CNTW-1:0] CNT
);

    localparam int            CW      = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB - 1);

    logic [N-1:0] s1;
    logic [N-1:0] s2;
    logic         l_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= SW;
            s2 <= s1;
        end
    end

    // Each bit commits a new level only after DEB consecutive disagreeing samples.
    generate
        for (genvar i = 0; i < N; i++) begin : g_bit
            logic [CW-1:0] deb_cnt;
            logic          level;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    deb_cnt <= '0;
                    level   <= 1'b0;
                end else if (s2[i] == level) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_MAX) begin
                    level   <= s2[i];
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + CW'(1);
                end
            end

            assign SWD[i] = level;
        end
    endgenerate

    always_comb begin
        l_next = 1'b0;
        case (MODE)
            2'b00:   l_next = &SWD;
            2'b01:   l_next = |SWD;
            2'b10:   l_next = ^SWD;
            default: l_next = ~&SWD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            L    <= 1'b0;
            EDGE <= 1'b0;
            CNT  <= '0;
        end else begin
            L    <= l_next;
            EDGE <= (l_next != L);
            if (l_next != L) begin
                CNT <= CNT + CNTW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/debounced_gate.md
DEBOUNCED_GATE -- requirements
Module: debounced_gate

Interface
REQ-001 The block SHALL have parameter N, default 2, number of switch inputs (legal N >= 1).
REQ-002 The block SHALL have parameter DEB, default 4, debounce stability length in clock cycles (legal DEB >= 1).
REQ-003 The block SHALL have parameter CNTW, default 8, width of the output-change counter (legal CNTW >= 1).
REQ-004 CLK  input  1  sole clock, all state updates on its rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 SW  input  N  raw asynchronous switch levels, may bounce.
REQ-007 MODE  input  2  gate function select, sampled every edge.
REQ-008 SWD  output  N  debounced switch levels, registered.
REQ-009 L  output  1  gate result over SWD, registered.
REQ-010 EDGE  output  1  one-cycle pulse marking a change of L.
REQ-011 CNT  output  CNTW  count of L changes since reset.

Function
REQ-012 Each SW[i] SHALL pass through its own two-flop synchronizer (s1, s2) before debouncing.
REQ-013 Each bit SHALL have a debounce counter: s2 == SWD[i] clears it; s2 != SWD[i] and counter < DEB-1 increments it; s2 != SWD[i] and counter == DEB-1 loads SWD[i] <= s2 and clears it.
REQ-014 A level first sampled into s1 at edge k and held stable SHALL appear on SWD[i] after edge k+1+DEB; any reversion before that edge SHALL leave SWD[i] unchanged and the counter cleared.
REQ-015 Bits SHALL debounce independently; simultaneous changes on several bits SHALL each follow REQ-014 without interaction.
REQ-016 L SHALL be registered from the current SWD and MODE: 00 AND of all bits, 01 OR, 10 XOR (odd parity), 11 NAND.
REQ-017 L SHALL therefore change one edge after SWD changes, and one edge after a MODE change.
REQ-018 EDGE SHALL be 1 for exactly the cycle following any edge at which L took a value different from its previous value, else 0.
REQ-019 CNT SHALL increment by 1 on each edge at which EDGE is loaded with 1, wrapping from 2^CNTW-1 to 0.
REQ-020 With N = 1, AND/OR/XOR SHALL equal SWD[0] and NAND its inverse.
REQ-021 With DEB = 1, a stable change SHALL reach SWD after edge k+2.

Reset
REQ-022 RST high at an edge SHALL clear s1, s2, all debounce counters, SWD, L, EDGE and CNT to 0, overriding all other activity that edge.
REQ-023 Reset asserted mid-debounce SHALL discard the partial count; after release, timing restarts per REQ-014 from the first post-reset sample.
REQ-024 On the first edge after release, if f(SWD=0, MODE) = 1 (NAND), L SHALL go to 1 with EDGE = 1 and CNT = 1; no suppression applies.

Verification (N=2, DEB=4, CNTW=8)
REQ-025 Reset: RST=1 two cycles with SW=11, MODE=00 -> SWD=00, L=0, EDGE=0, CNT=0 throughout.
REQ-026 AND sequence: MODE=00, SW 00->01->11->10, each held 12 cycles -> L 0,0,1,0; SWD change exactly DEB+2 edges after SW change edge, L one edge later; EDGE pulses twice; CNT=2.
REQ-027 Bounce rejection: SW0 pulsed 1 for 3 cycles, then 0 -> SWD, L unchanged; EDGE never 1; CNT unchanged.
REQ-028 Mode switch: SWD=01 stable, L=0 under AND; MODE set to 01 -> L=1 next edge, EDGE=1 one cycle, CNT+1; MODE 11 -> L=1 unchanged, no EDGE.
REQ-029 Wrap: XOR mode, SW0 toggled with 12-cycle holds 256 times -> 256 EDGE pulses, CNT returns to 0.
REQ-030 Reset mid-debounce: SW0 0->1, RST pulsed one cycle 3 edges later with SW0 held 1 -> SWD[0] rises 2+DEB edges after the first post-reset edge, not earlier.
